// File: rtl/shoe_shuffle_if.sv
// Seed-source / game-controller side bundle of the shoe shuffler.
// The master drives the requests; the slave is the shuffler itself.
interface shoe_shuffle_if #(
  parameter int SEED_W = 16,
  parameter int IDX_W  = 9
);
  logic              shuffleFlag;
  logic [SEED_W-1:0] seed;
  logic              dealReq;
  logic              loadFlag;
  logic              busy;
  logic              cardValid;
  logic [5:0]        card;
  logic [IDX_W-1:0]  cardsLeft;
  logic              empty;
  logic              cutReached;

  modport master (
    output shuffleFlag, seed, dealReq,
    input  loadFlag, busy, cardValid, card, cardsLeft, empty, cutReached
  );

  modport slave (
    input  shuffleFlag, seed, dealReq,
    output loadFlag, busy, cardValid, card, cardsLeft, empty, cutReached
  );
endinterface

// File: rtl/shoe_shuffle.sv
// Multi-deck shoe: filled in order, Fisher-Yates shuffled in place by a seeded
// Galois LFSR, then dealt one card per request.
module shoe_shuffle #(
  parameter int NUM_DECKS = 1,
  parameter int SEED_W    = 16,
  parameter int CUT_CARDS = 0,
  parameter int IDX_W     = 9
) (
  input  logic          clk,
  input  logic          rst,
  shoe_shuffle_if.slave bus
);
  localparam int N  = 52 * NUM_DECKS;
  localparam int AW = $clog2(N);
  localparam logic [SEED_W-1:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [SEED_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]  FULL_SHOE    = IDX_W'(N);
  localparam logic [IDX_W-1:0]  CUT_LEVEL    = IDX_W'(CUT_CARDS);

  typedef enum logic [1:0] {IDLE, INIT, SHUF, DEAL} state_t;

  state_t            state_q, state_d;
  logic              shuffle_q;
  logic              start, accept, swap_ok, do_deal;
  logic [SEED_W-1:0] lfsr_q, lfsr_step;
  logic [IDX_W-1:0]  idx_q, rnd, left_q;
  logic [AW-1:0]     ptr_q;
  logic [5:0]        init_val_q;
  logic              load_q, valid_q;
  logic [5:0]        card_q;
  logic [5:0]        mem [N];

  assign start     = bus.shuffleFlag & ~shuffle_q;
  assign lfsr_step = {1'b0, lfsr_q[SEED_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign rnd       = lfsr_step[IDX_W-1:0];
  assign swap_ok   = (rnd <= idx_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    do_deal = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = INIT;
        accept  = 1'b1;
      end
      INIT: if (idx_q == LAST_IDX) state_d = SHUF;
      SHUF: if (swap_ok && idx_q == IDX_W'(1)) state_d = DEAL;
      DEAL: if (start) begin
        state_d = INIT;
        accept  = 1'b1;
      end else begin
        do_deal = bus.dealReq && (left_q != '0);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shuffle_q  <= 1'b0;
      lfsr_q     <= LFSR_DEFAULT;
      idx_q      <= '0;
      ptr_q      <= '0;
      left_q     <= '0;
      init_val_q <= '0;
      load_q     <= 1'b0;
      valid_q    <= 1'b0;
      card_q     <= '0;
    end else begin
      shuffle_q <= bus.shuffleFlag;
      load_q    <= 1'b0;
      valid_q   <= do_deal;
      if (accept) begin
        lfsr_q     <= (bus.seed == '0) ? LFSR_DEFAULT : bus.seed;
        idx_q      <= '0;
        init_val_q <= '0;
        left_q     <= '0;
        ptr_q      <= '0;
      end
      unique case (state_q)
        INIT: begin
          // Index parks on the last slot so SHUF starts from i = N-1.
          if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
          init_val_q <= (init_val_q == 6'd51) ? 6'd0 : init_val_q + 6'd1;
        end
        SHUF: begin
          lfsr_q <= lfsr_step;
          if (swap_ok) begin
            idx_q <= idx_q - IDX_W'(1);
            if (idx_q == IDX_W'(1)) begin
              load_q <= 1'b1;
              left_q <= FULL_SHOE;
              ptr_q  <= '0;
            end
          end
        end
        DEAL: if (do_deal) begin
          card_q <= mem[ptr_q];
          ptr_q  <= ptr_q + AW'(1);
          left_q <= left_q - IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the card array is deliberately not reset; INIT rewrites every slot before use.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[idx_q[AW-1:0]] <= init_val_q;
    end else if (state_q == SHUF && swap_ok) begin
      // rnd <= idx_q < N here, so the truncated index stays in range.
      mem[idx_q[AW-1:0]] <= mem[rnd[AW-1:0]];
      mem[rnd[AW-1:0]]   <= mem[idx_q[AW-1:0]];
    end
  end

  assign bus.loadFlag   = load_q;
  assign bus.busy       = (state_q == INIT) || (state_q == SHUF);
  assign bus.cardValid  = valid_q;
  assign bus.card       = card_q;
  assign bus.cardsLeft  = left_q;
  assign bus.empty      = (left_q == '0);
  assign bus.cutReached = (left_q <= CUT_LEVEL);
endmodule

// File: tb/tb_shoe_shuffle.sv
// Directed bench for shoe_shuffle: one single-deck shoe (cut at 10) and one
// double-deck shoe, checked against a reference Fisher-Yates model.
module tb_shoe_shuffle;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shoe_shuffle_if #(.SEED_W(16), .IDX_W(9)) if1 ();
  shoe_shuffle_if #(.SEED_W(16), .IDX_W(9)) if2 ();

  shoe_shuffle #(.NUM_DECKS(1), .SEED_W(16), .CUT_CARDS(10), .IDX_W(9)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  shoe_shuffle #(.NUM_DECKS(2), .SEED_W(16), .CUT_CARDS(0), .IDX_W(9)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  int checks   = 0;
  int failures = 0;
  int exp_seq [104];
  int got_seq [104];
  int ref_seq [104];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference shuffle: fills exp_seq, returns the number of SHUF cycles.
  function automatic int model(input logic [15:0] s, input int n);
    logic [15:0] l;
    logic [8:0]  r;
    int m [104];
    int i, cyc, ri, t;
    l = (s == 16'h0) ? 16'hACE1 : s;
    for (int k = 0; k < n; k++) m[k] = k % 52;
    i   = n - 1;
    cyc = 0;
    while (i > 0) begin
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      r = l[8:0];
      ri = int'(r);
      cyc++;
      if (ri <= i) begin
        t = m[i]; m[i] = m[ri]; m[ri] = t;
        i--;
      end
    end
    for (int k = 0; k < n; k++) exp_seq[k] = m[k];
    return cyc;
  endfunction

  function automatic logic valid_of(input int d);
    return (d == 1) ? if1.cardValid : if2.cardValid;
  endfunction
  function automatic logic busy_of(input int d);
    return (d == 1) ? if1.busy : if2.busy;
  endfunction
  function automatic logic load_of(input int d);
    return (d == 1) ? if1.loadFlag : if2.loadFlag;
  endfunction
  function automatic int card_of(input int d);
    return (d == 1) ? int'(if1.card) : int'(if2.card);
  endfunction
  function automatic int left_of(input int d);
    return (d == 1) ? int'(if1.cardsLeft) : int'(if2.cardsLeft);
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 1) if1.dealReq = v; else if2.dealReq = v;
  endtask
  task automatic set_flag(input int d, input logic v);
    if (d == 1) if1.shuffleFlag = v; else if2.shuffleFlag = v;
  endtask
  task automatic set_seed(input int d, input logic [15:0] s);
    if (d == 1) if1.seed = s; else if2.seed = s;
  endtask

  // Counts busy cycles and loadFlag pulses until the shuffle completes.
  task automatic wait_load(input int d, output int busy_cyc, output int loads, output int left_at_load);
    busy_cyc = 0; loads = 0; left_at_load = -1;
    for (int c = 0; c < 20000 && loads == 0; c++) begin
      @(negedge clk);
      if (busy_of(d)) busy_cyc++;
      if (load_of(d)) begin
        loads++;
        left_at_load = left_of(d);
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (load_of(d)) loads++;
    end
  endtask

  task automatic run_shuffle(input int d, input logic [15:0] s,
                             output int busy_cyc, output int loads, output int left_at_load);
    set_flag(d, 1'b0);
    set_seed(d, s);
    @(negedge clk);
    set_flag(d, 1'b1);
    wait_load(d, busy_cyc, loads, left_at_load);
  endtask

  // Deals n cards into got_seq[base..]; counts cardsLeft values off the countdown.
  task automatic deal(input int d, input int n, input int base, input int left0,
                      output int got, output int bad_left);
    int cnt = 0;
    int bl  = 0;
    set_req(d, 1'b1);
    for (int c = 0; c < n + 8 && cnt < n; c++) begin
      @(negedge clk);
      if (valid_of(d)) begin
        got_seq[base + cnt] = card_of(d);
        cnt++;
        if (left_of(d) != left0 - cnt) bl++;
        if (cnt == n) set_req(d, 1'b0);
      end
    end
    set_req(d, 1'b0);
    got = cnt;
    bad_left = bl;
  endtask

  function automatic int hist_bad(input int n, input int per);
    int h [52];
    int bad = 0;
    for (int v = 0; v < 52; v++) h[v] = 0;
    for (int k = 0; k < n; k++) begin
      if (got_seq[k] >= 0 && got_seq[k] < 52) h[got_seq[k]]++;
      else bad++;
    end
    for (int v = 0; v < 52; v++) if (h[v] != per) bad++;
    return bad;
  endfunction

  function automatic int diff_exp(input int n);
    int dcount = 0;
    for (int k = 0; k < n; k++) if (got_seq[k] != exp_seq[k]) dcount++;
    return dcount;
  endfunction

  function automatic int diff_ref(input int n);
    int dcount = 0;
    for (int k = 0; k < n; k++) if (got_seq[k] != ref_seq[k]) dcount++;
    return dcount;
  endfunction

  task automatic save_ref(input int n);
    for (int k = 0; k < n; k++) ref_seq[k] = got_seq[k];
  endtask

  initial begin
    int cyc, bc, ld, lf, got, bl, tmp_cnt, tmp_valid;

    // Reset state
    rst = 1'b1;
    if1.shuffleFlag = 1'b0; if1.seed = '0; if1.dealReq = 1'b0;
    if2.shuffleFlag = 1'b0; if2.seed = '0; if2.dealReq = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_loadFlag", if1.loadFlag, 0);
    check("rst_busy", if1.busy, 0);
    check("rst_cardValid", if1.cardValid, 0);
    check("rst_card", if1.card, 0);
    check("rst_cardsLeft", if1.cardsLeft, 0);
    check("rst_empty", if1.empty, 1);
    check("rst_cutReached", if1.cutReached, 1);
    check("rst_cut_d2", if2.cutReached, 1);
    rst = 1'b0;

    // Requests in IDLE are ignored
    if1.dealReq = 1'b1;
    tmp_valid = 0;
    repeat (4) begin
      @(negedge clk);
      if (if1.cardValid) tmp_valid++;
    end
    if1.dealReq = 1'b0;
    check("idle_no_deal", tmp_valid, 0);
    check("idle_left", if1.cardsLeft, 0);

    // Full shuffle and deal with cut tracking, seed 002B
    cyc = model(16'h002B, 52);
    run_shuffle(1, 16'h002B, bc, ld, lf);
    check("s2b_busy_cycles", bc, 52 + cyc);
    check("s2b_busy_min", (bc >= 103), 1);
    check("s2b_loads", ld, 1);
    check("s2b_left_at_load", lf, 52);
    check("s2b_left_after", if1.cardsLeft, 52);
    check("s2b_cut_full", if1.cutReached, 0);
    deal(1, 41, 0, 52, got, bl);
    check("s2b_41_left", if1.cardsLeft, 11);
    check("s2b_41_cut", if1.cutReached, 0);
    deal(1, 1, 41, 11, tmp_cnt, tmp_valid);
    got += tmp_cnt; bl += tmp_valid;
    check("s2b_42_left", if1.cardsLeft, 10);
    check("s2b_42_cut", if1.cutReached, 1);
    deal(1, 10, 42, 10, tmp_cnt, tmp_valid);
    got += tmp_cnt; bl += tmp_valid;
    check("s2b_dealt", got, 52);
    check("s2b_countdown", bl, 0);
    check("s2b_empty", if1.empty, 1);
    check("s2b_hist", hist_bad(52, 1), 0);
    check("s2b_vs_model", diff_exp(52), 0);

    // 53rd request on an empty shoe
    if1.dealReq = 1'b1;
    tmp_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (if1.cardValid) tmp_valid++;
    end
    if1.dealReq = 1'b0;
    check("empty_no_deal", tmp_valid, 0);
    check("empty_left", if1.cardsLeft, 0);

    // Determinism: same seed twice
    cyc = model(16'h1234, 52);
    run_shuffle(1, 16'h1234, bc, ld, lf);
    check("s1234a_busy", bc, 52 + cyc);
    deal(1, 52, 0, 52, got, bl);
    check("s1234a_vs_model", diff_exp(52), 0);
    save_ref(52);
    run_shuffle(1, 16'h1234, bc, ld, lf);
    deal(1, 52, 0, 52, got, bl);
    check("s1234b_dealt", got, 52);
    check("s1234_repeat", diff_ref(52), 0);

    // Seed 0 behaves as ACE1
    run_shuffle(1, 16'h0000, bc, ld, lf);
    deal(1, 52, 0, 52, got, bl);
    void'(model(16'hACE1, 52));
    check("s0_vs_model", diff_exp(52), 0);
    save_ref(52);
    run_shuffle(1, 16'hACE1, bc, ld, lf);
    deal(1, 52, 0, 52, got, bl);
    check("s0_eq_ace1", diff_ref(52), 0);

    // Seed 0001 differs from 1234
    void'(model(16'h1234, 52));
    for (int k = 0; k < 52; k++) ref_seq[k] = exp_seq[k];
    run_shuffle(1, 16'h0001, bc, ld, lf);
    deal(1, 52, 0, 52, got, bl);
    check("s1_differs", (diff_ref(52) != 0), 1);
    check("s1_hist", hist_bad(52, 1), 0);

    // Restart after 5 deals, with a request colliding with the start
    run_shuffle(1, 16'h1234, bc, ld, lf);
    if1.shuffleFlag = 1'b0;
    deal(1, 5, 0, 52, got, bl);
    check("restart_pre_left", if1.cardsLeft, 47);
    if1.seed = 16'h5A5A;
    if1.dealReq = 1'b1;
    if1.shuffleFlag = 1'b1;
    @(negedge clk);
    if1.dealReq = 1'b0;
    check("restart_busy", if1.busy, 1);
    check("restart_left", if1.cardsLeft, 0);
    check("restart_no_card", if1.cardValid, 0);
    cyc = model(16'h5A5A, 52);
    wait_load(1, bc, ld, lf);
    check("restart_busy_cycles", bc + 1, 52 + cyc);
    check("restart_loads", ld, 1);
    deal(1, 52, 0, 52, got, bl);
    check("restart_hist", hist_bad(52, 1), 0);
    check("restart_vs_model", diff_exp(52), 0);

    // Reset in the middle of SHUF
    if1.shuffleFlag = 1'b0;
    if1.seed = 16'h0BAD;
    @(negedge clk);
    if1.shuffleFlag = 1'b1;
    repeat (60) @(negedge clk);
    check("midshuf_busy", if1.busy, 1);
    rst = 1'b1;
    if1.shuffleFlag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midshuf_rst_busy", if1.busy, 0);
    check("midshuf_rst_load", if1.loadFlag, 0);
    check("midshuf_rst_left", if1.cardsLeft, 0);
    bc = 0; ld = 0;
    repeat (3000) begin
      @(negedge clk);
      if (if1.busy) bc++;
      if (if1.loadFlag) ld++;
    end
    check("midshuf_idle_busy", bc, 0);
    check("midshuf_idle_loads", ld, 0);

    // Double-deck shoe
    cyc = model(16'h002B, 104);
    run_shuffle(2, 16'h002B, bc, ld, lf);
    check("d2_busy_cycles", bc, 104 + cyc);
    check("d2_loads", ld, 1);
    check("d2_left_at_load", lf, 104);
    deal(2, 104, 0, 104, got, bl);
    check("d2_dealt", got, 104);
    check("d2_countdown", bl, 0);
    check("d2_empty", if2.empty, 1);
    check("d2_hist", hist_bad(104, 2), 0);
    check("d2_vs_model", diff_exp(104), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
